// File: rtl/video_page_engine_if.sv
// Command handshake and page-RAM bus shared by anotherworld_cpu, the video page engine and the RAM.
// The slave view is the engine; the master view is its environment (CPU side plus RAM read data).
interface video_page_engine_if #(
  parameter int PIX_AW = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [7:0]        cmd_a;
  logic [7:0]        cmd_b;
  logic              cmd_done;
  logic [PIX_AW+1:0] mem_addr;
  logic              mem_we;
  logic              mem_re;
  logic [3:0]        mem_wdata;
  logic [3:0]        mem_rdata;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, mem_rdata,
    input  cmd_ready, cmd_done, mem_addr, mem_we, mem_re, mem_wdata
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, mem_rdata,
    output cmd_ready, cmd_done, mem_addr, mem_we, mem_re, mem_wdata
  );
endinterface

// File: rtl/video_page_engine.sv
// Executes the VM video opcodes (select/fill/copy/blit) one at a time against a 4-page 4bpp RAM,
// and owns the work-page and display-page registers.
module video_page_engine #(
  parameter int PIXELS = 64000,
  parameter int PIX_AW = 16
) (
  input  logic               clk,
  input  logic               reset,
  video_page_engine_if.slave bus,
  input  logic               vsync,
  output logic [1:0]         work_page,
  output logic [1:0]         display_page
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_COPY_RD,
    S_COPY_WR,
    S_BLIT_WAIT
  } state_t;

  localparam logic [1:0]        OP_SELECT = 2'd0;
  localparam logic [1:0]        OP_FILL   = 2'd1;
  localparam logic [1:0]        OP_COPY   = 2'd2;
  localparam logic [1:0]        OP_BLIT   = 2'd3;
  localparam logic [PIX_AW-1:0] LAST_PIX  = PIX_AW'(PIXELS - 1);

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_work;
  logic [1:0]        r_disp;
  logic [1:0]        r_src;
  logic [1:0]        r_dst;
  logic [3:0]        r_color;
  logic [PIX_AW-1:0] r_cnt;
  logic              r_done;
  logic              r_vsync;
  logic              r_vsyncInWait;

  logic              w_accept;
  logic [1:0]        w_pageA;
  logic [1:0]        w_pageB;
  logic              w_lastPix;
  logic              w_vsyncRise;
  logic              w_done;
  logic              w_we;
  logic              w_re;
  logic [PIX_AW+1:0] w_addr;
  logic [3:0]        w_wdata;

  // 0xFE/0xFF alias the current display/work page; everything else uses its low two bits.
  function automatic logic [1:0] resolvePage(input logic [7:0] op,
                                             input logic [1:0] work,
                                             input logic [1:0] disp);
    case (op)
      8'hFE:   return disp;
      8'hFF:   return work;
      default: return op[1:0];
    endcase
  endfunction

  assign w_accept  = bus.cmd_valid && (r_state == S_IDLE);
  assign w_pageA   = resolvePage(bus.cmd_a, r_work, r_disp);
  assign w_pageB   = resolvePage(bus.cmd_b, r_work, r_disp);
  assign w_lastPix = (r_cnt == LAST_PIX);
  // Only an edge whose low and high samples were both taken while waiting may complete a blit.
  assign w_vsyncRise = r_vsyncInWait && !r_vsync && vsync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_done  = 1'b0;
    w_we    = 1'b0;
    w_re    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (bus.cmd_op)
            OP_SELECT: w_done = 1'b1;
            OP_FILL:   w_next = S_FILL;
            OP_COPY: begin
              if (w_pageA == w_pageB) w_done = 1'b1;
              else                    w_next = S_COPY_RD;
            end
            OP_BLIT:   w_next = S_BLIT_WAIT;
            default:   w_next = S_IDLE;
          endcase
        end
      end
      S_FILL: begin
        w_we    = 1'b1;
        w_addr  = {r_dst, r_cnt};
        w_wdata = r_color;
        if (w_lastPix) begin
          w_next = S_IDLE;
          w_done = 1'b1;
        end
      end
      S_COPY_RD: begin
        w_re   = 1'b1;
        w_addr = {r_src, r_cnt};
        w_next = S_COPY_WR;
      end
      S_COPY_WR: begin
        w_we    = 1'b1;
        w_addr  = {r_dst, r_cnt};
        w_wdata = bus.mem_rdata;
        if (w_lastPix) begin
          w_next = S_IDLE;
          w_done = 1'b1;
        end else begin
          w_next = S_COPY_RD;
        end
      end
      S_BLIT_WAIT: begin
        if (w_vsyncRise) begin
          w_next = S_IDLE;
          w_done = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_work        <= 2'd0;
      r_disp        <= 2'd1;
      r_src         <= 2'd0;
      r_dst         <= 2'd0;
      r_color       <= 4'd0;
      r_cnt         <= '0;
      r_done        <= 1'b0;
      r_vsync       <= 1'b0;
      r_vsyncInWait <= 1'b0;
    end else begin
      r_done        <= w_done;
      r_vsync       <= vsync;
      r_vsyncInWait <= (r_state == S_BLIT_WAIT);
      if (w_accept) begin
        r_cnt   <= '0;
        r_src   <= w_pageA;
        r_dst   <= (bus.cmd_op == OP_COPY) ? w_pageB : w_pageA;
        r_color <= bus.cmd_b[3:0];
        if (bus.cmd_op == OP_SELECT) r_work <= w_pageA;
      end else if ((r_state == S_FILL || r_state == S_COPY_WR) && !w_lastPix) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == S_BLIT_WAIT && w_vsyncRise) r_disp <= r_dst;
    end
  end

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.cmd_done  = r_done;
  assign bus.mem_addr  = w_addr;
  assign bus.mem_we    = w_we;
  assign bus.mem_re    = w_re;
  assign bus.mem_wdata = w_wdata;
  assign work_page     = r_work;
  assign display_page  = r_disp;

endmodule

// File: tb/tb_video_page_engine.sv
// Directed bench for video_page_engine with PIXELS=16, a behavioural sync page RAM and
// hand-computed expectations for every command type.
module tb_video_page_engine;

  localparam int PIXELS = 16;
  localparam int PIX_AW = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       vsync;
  logic [1:0] workPage;
  logic [1:0] displayPage;

  int checkCount = 0;
  int failCount  = 0;
  int cycle      = 0;

  logic [3:0] ram [0:63];
  logic       preEn;
  logic [5:0] preAddr;
  logic [3:0] preData;

  video_page_engine_if #(.PIX_AW(PIX_AW)) vif ();

  video_page_engine #(.PIXELS(PIXELS), .PIX_AW(PIX_AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (vif.slave),
    .vsync       (vsync),
    .work_page   (workPage),
    .display_page(displayPage)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Synchronous page RAM: read data appears the cycle after mem_re.
  always @(posedge clk) begin
    if (preEn)           ram[preAddr] <= preData;
    else if (vif.mem_we) ram[vif.mem_addr] <= vif.mem_wdata;
    if (vif.mem_re)      vif.mem_rdata <= ram[vif.mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h at cycle %0d", tag, observed, expected, cycle);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) checkOutput("we_re_exclusive", 32'(vif.mem_we & vif.mem_re), 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady();
    int n = 0;
    while (!vif.cmd_ready && n < 200) begin
      tick();
      n++;
    end
    checkOutput("ready_wait", 32'(vif.cmd_ready), 32'd1);
  endtask

  // Presents one command, waits for acceptance, and returns in the cycle after acceptance.
  task automatic applyStimulus(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    vif.cmd_valid = 1'b1;
    vif.cmd_op    = op;
    vif.cmd_a     = a;
    vif.cmd_b     = b;
    waitReady();
    tick();
    vif.cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0, c1, c2;
    reset         = 1'b1;
    vsync         = 1'b0;
    preEn         = 1'b0;
    preAddr       = '0;
    preData       = '0;
    vif.cmd_valid = 1'b0;
    vif.cmd_op    = 2'd0;
    vif.cmd_a     = 8'd0;
    vif.cmd_b     = 8'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    checkOutput("rst_ready", 32'(vif.cmd_ready), 32'd1);
    checkOutput("rst_strobes", 32'({vif.mem_we, vif.mem_re}), 32'd0);
    checkOutput("rst_addr_wdata", 32'({vif.mem_addr, vif.mem_wdata}), 32'd0);
    checkOutput("rst_work", 32'(workPage), 32'd0);
    checkOutput("rst_display", 32'(displayPage), 32'd1);
    checkOutput("rst_done", 32'(vif.cmd_done), 32'd0);
    repeat (3) tick();
    checkOutput("idle_strobes", 32'({vif.mem_we, vif.mem_re, vif.cmd_done}), 32'd0);

    // FILL page 2 with colour 7; operands are scribbled after acceptance.
    applyStimulus(2'd1, 8'h02, 8'h07);
    vif.cmd_a = 8'h01;
    vif.cmd_b = 8'h03;
    for (int i = 0; i < PIXELS; i++) begin
      checkOutput("fill_pixel", 32'({vif.mem_we, vif.mem_re, vif.mem_addr, vif.mem_wdata, vif.cmd_done}),
                  32'({1'b1, 1'b0, 2'd2, 4'(i), 4'd7, 1'b0}));
      checkOutput("fill_not_ready", 32'(vif.cmd_ready), 32'd0);
      tick();
    end
    checkOutput("fill_done", 32'({vif.cmd_done, vif.cmd_ready, vif.mem_we}), 32'b110);
    tick();
    checkOutput("fill_done_pulse", 32'(vif.cmd_done), 32'd0);

    // Reset in the middle of a FILL must drop the strobes without waiting for a clock.
    applyStimulus(2'd1, 8'h00, 8'h0A);
    repeat (3) tick();
    checkOutput("fill2_active", 32'(vif.mem_we), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("midrst_strobes", 32'({vif.mem_we, vif.mem_re}), 32'd0);
    checkOutput("midrst_addr", 32'(vif.mem_addr), 32'd0);
    checkOutput("midrst_ready", 32'(vif.cmd_ready), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("midrst_pages", 32'({workPage, displayPage}), 32'({2'd0, 2'd1}));

    // Preload page 1 with i^5, then COPY page 1 -> page 3.
    for (int i = 0; i < PIXELS; i++) begin
      preEn   = 1'b1;
      preAddr = {2'd1, 4'(i)};
      preData = 4'(i) ^ 4'd5;
      tick();
    end
    preEn = 1'b0;
    applyStimulus(2'd2, 8'h01, 8'h03);
    for (int i = 0; i < PIXELS; i++) begin
      checkOutput("copy_read", 32'({vif.mem_we, vif.mem_re, vif.mem_addr, vif.cmd_done}),
                  32'({1'b0, 1'b1, 2'd1, 4'(i), 1'b0}));
      tick();
      checkOutput("copy_write", 32'({vif.mem_we, vif.mem_re, vif.mem_addr, vif.mem_wdata, vif.cmd_done}),
                  32'({1'b1, 1'b0, 2'd3, 4'(i), 4'(i) ^ 4'd5, 1'b0}));
      tick();
    end
    checkOutput("copy_done", 32'({vif.cmd_done, vif.cmd_ready, vif.mem_we, vif.mem_re}), 32'b1100);
    checkOutput("copy_ram0", 32'(ram[6'h30]), 32'd5);
    checkOutput("copy_ram9", 32'(ram[6'h39]), 32'd12);
    checkOutput("copy_ram15", 32'(ram[6'h3F]), 32'd10);

    // COPY work page (0) onto page 0 is a no-op finishing next cycle.
    applyStimulus(2'd2, 8'hFF, 8'h00);
    checkOutput("copy_noop", 32'({vif.cmd_done, vif.cmd_ready, vif.mem_we, vif.mem_re}), 32'b1100);

    applyStimulus(2'd0, 8'hFE, 8'h00);
    checkOutput("select_fe", 32'({vif.cmd_done, workPage}), 32'({1'b1, 2'd1}));
    tick();
    checkOutput("select_done_pulse", 32'(vif.cmd_done), 32'd0);
    applyStimulus(2'd0, 8'h07, 8'h00);
    checkOutput("select_07", 32'({vif.cmd_done, workPage}), 32'({1'b1, 2'd3}));
    applyStimulus(2'd0, 8'h02, 8'h00);
    checkOutput("select_02", 32'(workPage), 32'd2);

    // BLIT work page; vsync rises 10 cycles after acceptance.
    vsync = 1'b0;
    applyStimulus(2'd3, 8'hFF, 8'h00);
    for (int i = 0; i < 9; i++) begin
      checkOutput("blit_wait", 32'({vif.cmd_done, vif.cmd_ready, displayPage, vif.mem_we, vif.mem_re}),
                  32'({1'b0, 1'b0, 2'd1, 2'b00}));
      tick();
    end
    vsync = 1'b1;
    tick();
    checkOutput("blit_done", 32'({vif.cmd_done, vif.cmd_ready, displayPage}), 32'({1'b1, 1'b1, 2'd2}));
    tick();
    checkOutput("blit_done_pulse", 32'(vif.cmd_done), 32'd0);

    // vsync already high at acceptance: only a fresh low-to-high edge completes the blit.
    applyStimulus(2'd3, 8'h01, 8'h00);
    for (int i = 0; i < 5; i++) begin
      checkOutput("blit_high_wait", 32'({vif.cmd_done, displayPage}), 32'({1'b0, 2'd2}));
      tick();
    end
    vsync = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("blit_low_wait", 32'({vif.cmd_done, displayPage}), 32'({1'b0, 2'd2}));
      tick();
    end
    vsync = 1'b1;
    tick();
    checkOutput("blit_new_edge", 32'({vif.cmd_done, displayPage}), 32'({1'b1, 2'd1}));
    vsync = 1'b0;
    tick();

    // cmd_valid held high across SELECT, FILL, BLIT.
    vif.cmd_valid = 1'b1;
    vif.cmd_op    = 2'd0;
    vif.cmd_a     = 8'h00;
    vif.cmd_b     = 8'h00;
    waitReady();
    c0 = cycle;
    tick();
    vif.cmd_op = 2'd1;
    vif.cmd_a  = 8'h00;
    vif.cmd_b  = 8'h05;
    waitReady();
    c1 = cycle;
    tick();
    vif.cmd_op = 2'd3;
    vif.cmd_a  = 8'h03;
    vif.cmd_b  = 8'h00;
    waitReady();
    c2 = cycle;
    tick();
    vif.cmd_valid = 1'b0;
    checkOutput("b2b_fill_accept", 32'(c1 - c0), 32'd1);
    checkOutput("b2b_blit_accept", 32'(c2 - c1), 32'd17);
    checkOutput("b2b_work", 32'(workPage), 32'd0);
    checkOutput("b2b_fill_ram0", 32'(ram[6'h00]), 32'd5);
    checkOutput("b2b_fill_ram15", 32'(ram[6'h0F]), 32'd5);
    tick();
    tick();
    checkOutput("b2b_blit_wait", 32'({vif.cmd_done, vif.cmd_ready}), 32'd0);
    vsync = 1'b1;
    tick();
    checkOutput("b2b_blit_done", 32'({vif.cmd_done, displayPage}), 32'({1'b1, 2'd3}));
    vsync = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
